// File: rtl/std_div_pipe.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, go/done handshake.
// Optional macro STD_DIV_ZERO_FLAG_EN adds a fast divide-by-zero path and the div_by_zero flag.
module std_div_pipe #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
`ifdef STD_DIV_ZERO_FLAG_EN
  output logic             div_by_zero,
`endif
  output logic             done
);

  localparam int unsigned CntW = $clog2(width + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [width-1:0] dividend_q, dividend_d;
  logic [width-1:0] divisor_q, divisor_d;
  logic [width-1:0] acc_q, acc_d;
  logic [width-1:0] quot_q, quot_d;
  logic [width-1:0] out_quot_q, out_quot_d;
  logic [width-1:0] out_rem_q, out_rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [width:0]   acc_shift;
  logic [width-1:0] acc_sub;
  logic             acc_ge;
`ifdef STD_DIV_ZERO_FLAG_EN
  logic             dbz_q, dbz_d;
`endif

  // acc_shift keeps the bit shifted out of acc so large divisors compare correctly.
  assign acc_shift = {acc_q, dividend_q[width-1]};
  assign acc_ge    = (acc_shift >= {1'b0, divisor_q});
  // When acc_ge holds the true difference fits in width bits.
  assign acc_sub   = acc_shift[width-1:0] - divisor_q;

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    acc_d      = acc_q;
    quot_d     = quot_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    cnt_d      = cnt_q;
`ifdef STD_DIV_ZERO_FLAG_EN
    dbz_d      = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (go) begin
          dividend_d = left;
          divisor_d  = right;
          acc_d      = '0;
          quot_d     = '0;
          cnt_d      = CntW'(width);
          state_d    = StBusy;
`ifdef STD_DIV_ZERO_FLAG_EN
          if (right == '0) begin
            out_quot_d = '1;
            out_rem_d  = left;
            dbz_d      = 1'b1;
            state_d    = StDone;
          end
`endif
        end
      end
      StBusy: begin
        dividend_d = {dividend_q[width-2:0], 1'b0};
        if (acc_ge) begin
          acc_d  = acc_sub;
          quot_d = {quot_q[width-2:0], 1'b1};
        end else begin
          acc_d  = acc_shift[width-1:0];
          quot_d = {quot_q[width-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          out_quot_d = quot_d;
          out_rem_d  = acc_d;
          state_d    = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      acc_q      <= '0;
      quot_q     <= '0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      cnt_q      <= '0;
`ifdef STD_DIV_ZERO_FLAG_EN
      dbz_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      acc_q      <= acc_d;
      quot_q     <= quot_d;
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      cnt_q      <= cnt_d;
`ifdef STD_DIV_ZERO_FLAG_EN
      dbz_q      <= dbz_d;
`endif
    end
  end

  assign out_quotient  = out_quot_q;
  assign out_remainder = out_rem_q;
  assign done          = (state_q == StDone);
`ifdef STD_DIV_ZERO_FLAG_EN
  assign div_by_zero   = dbz_q;
`endif

endmodule
